// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_sb
//  Brief    : Parametrised multi-read-port register file with write-to-read
//             bypass and a per-register busy scoreboard for RAW detection.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int              XLEN      = 32,
    parameter int              NREGS     = 32,
    parameter int              AW        = 5,
    parameter int              NRD       = 2,
    parameter int              ZERO_R0   = 1,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic [NREGS-1:0]     busy_vec
);

    localparam logic c_ZR0 = (ZERO_R0 != 0);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_we;
    logic [NREGS-1:0] w_busy_nxt;

    // Per-register write enable and scoreboard next state
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (c_ZR0 && gi == 0) begin : g_zero
                // Hard-wired zero register: never written, never busy
                assign w_we[gi]       = 1'b0;
                assign w_busy_nxt[gi] = 1'b0;
            end else begin : g_norm
                logic w_wb_hit;
                logic w_rsv_hit;
                assign w_wb_hit  = wb_en  && (wb_addr  == AW'(gi));
                assign w_rsv_hit = rsv_en && (rsv_addr == AW'(gi));
                assign w_we[gi]  = w_wb_hit;
                // A new reservation supersedes a completing older producer
                assign w_busy_nxt[gi] = w_rsv_hit ? 1'b1 :
                                        w_wb_hit  ? 1'b0 : r_busy[gi];
            end
        end
    endgenerate

    // Register storage: reset to RESET_VAL (zero register to 0), then writeback
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                r_regs[i] <= (c_ZR0 && i == 0) ? '0 : RESET_VAL;
            end else if (w_we[i]) begin
                r_regs[i] <= wb_data;
            end
        end
    end

    // Scoreboard busy bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    // Combinational read ports with writeback bypass
    genvar gk;
    generate
        for (gk = 0; gk < NRD; gk++) begin : g_rd
            logic [AW-1:0]   w_raddr;
            logic [XLEN-1:0] w_data;
            logic            w_busy;

            assign w_raddr = rd_addr[gk*AW +: AW];

            // Zero register beats bypass; bypass beats stored value and busy bit
            always_comb begin
                w_data = r_regs[w_raddr];
                w_busy = r_busy[w_raddr];
                if (c_ZR0 && w_raddr == '0) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end else if (wb_en && wb_addr == w_raddr) begin
                    w_data = wb_data;
                    w_busy = 1'b0;
                end
            end

            assign rd_data[gk*XLEN +: XLEN] = w_data;
            assign rd_busy[gk]              = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire
